// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg
//   Shared constants for the raster timing generator: the default
//   640x480@60 mode, a tiny simulation mode, and the axis-total helper.
//   No ports.
package vga_timing_gen_pkg;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int DEF_H_VIS     = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VIS     = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam bit DEF_HSYNC_POL = 1'b0;
    localparam bit DEF_VSYNC_POL = 1'b0;
    localparam int DEF_ACT_LEAD  = 1;
    localparam int DEF_HW        = 10;
    localparam int DEF_VW        = 10;

    // Tiny mode for fast simulation of whole frames
    localparam int SIM_H_VIS  = 8;
    localparam int SIM_H_FP   = 2;
    localparam int SIM_H_SYNC = 2;
    localparam int SIM_H_BP   = 2;
    localparam int SIM_V_VIS  = 4;
    localparam int SIM_V_FP   = 1;
    localparam int SIM_V_SYNC = 1;
    localparam int SIM_V_BP   = 1;

    function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Raster timing bus between the generator and its consumers.
//   master (generator): input ce; outputs hCount, vCount, hSync, vSync,
//                       hVis, vVis, nVis, vActive, lineEnd, frameStart.
//   slave  (consumer) : mirror of master.
interface vga_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10
);
    logic          ce;
    logic [HW-1:0] hCount;
    logic [VW-1:0] vCount;
    logic          hSync;
    logic          vSync;
    logic          hVis;
    logic          vVis;
    logic          nVis;
    logic          vActive;
    logic          lineEnd;
    logic          frameStart;

    modport master (
        input  ce,
        output hCount, vCount, hSync, vSync, hVis, vVis, nVis, vActive, lineEnd, frameStart
    );

    modport slave (
        output ce,
        input  hCount, vCount, hSync, vSync, hVis, vVis, nVis, vActive, lineEnd, frameStart
    );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_axis_counter
//   One raster axis: position counter 0..TOTAL-1 plus registered decodes of
//   the position held in the same cycle.
//   Ports: clk, nrst (sync, active-low), step (advance enable), sync_pol
//          (asserted sync level) -> count, wrap (count==TOTAL-1), vis,
//          sync, active (vis window advanced by LEAD positions).
module vga_axis_counter import vga_timing_gen_pkg::*; #(
    parameter int VIS  = 640,
    parameter int FP   = 16,
    parameter int SYNC = 96,
    parameter int BP   = 48,
    parameter int LEAD = 0,
    parameter int W    = 10
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         step,
    input  logic         sync_pol,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         vis,
    output logic         sync,
    output logic         active
);
    localparam int TOTAL = axis_total(VIS, FP, SYNC, BP);

    if (VIS < 1 || FP < 1 || SYNC < 1 || BP < 1 || LEAD < 0 ||
        LEAD > FP + SYNC + BP || TOTAL > (1 << W)) begin : g_bad_params
        $error("vga_axis_counter: illegal timing parameters");
    end

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] VIS_END = W'(VIS);
    localparam logic [W-1:0] SYNC_LO = W'(VIS + FP);
    localparam logic [W-1:0] SYNC_HI = W'(VIS + FP + SYNC);
    // Active window is the tail of the previous period plus the head of
    // the visible region; either piece may be empty.
    localparam bit           HAS_TAIL = (LEAD > 0);
    localparam bit           HAS_HEAD = (VIS > LEAD);
    localparam logic [W-1:0] ACT_LO   = W'(TOTAL - LEAD);
    localparam logic [W-1:0] ACT_HI   = W'(VIS - LEAD);

    logic [W-1:0] count_q, count_d;
    logic         wrap_q, vis_q, sync_q, active_q;

    // Reset is folded into the next position so every decode below is
    // simply the decode of count_d; this keeps outputs zero-skew.
    always_comb begin
        count_d = count_q;
        if (!nrst)
            count_d = LAST;
        else if (step)
            count_d = wrap_q ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        count_q  <= count_d;
        wrap_q   <= (count_d == LAST);
        vis_q    <= (count_d < VIS_END);
        sync_q   <= ((count_d >= SYNC_LO) && (count_d < SYNC_HI)) ? sync_pol : ~sync_pol;
        active_q <= (HAS_TAIL && (count_d >= ACT_LO)) || (HAS_HEAD && (count_d < ACT_HI));
    end

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign vis    = vis_q;
    assign sync   = sync_q;
    assign active = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator: horizontal/vertical counters with
//   sync, visibility, readout-activity and line/frame markers.
//   Ports: clk (pixel clock), nrst (sync, active-low),
//          bus (master): ce in; hCount, vCount, hSync, vSync, hVis, vVis,
//          nVis, vActive, lineEnd, frameStart out.
module vga_timing_gen import vga_timing_gen_pkg::*; #(
    parameter int H_VIS     = DEF_H_VIS,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VIS     = DEF_V_VIS,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = DEF_HSYNC_POL,
    parameter bit VSYNC_POL = DEF_VSYNC_POL,
    parameter int ACT_LEAD  = DEF_ACT_LEAD,
    parameter int HW        = DEF_HW,
    parameter int VW        = DEF_VW
) (
    input logic              clk,
    input logic              nrst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = axis_total(H_VIS, H_FP, H_SYNC, H_BP);

    logic hWrap, vWrap;
    logic hAct_unused;
    logic lineEnd_q, lineEnd_d;
    logic frameStart_q, frameStart_d;

    vga_axis_counter #(
        .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .LEAD(0), .W(HW)
    ) u_h (
        .clk      (clk),
        .nrst     (nrst),
        .step     (bus.ce),
        .sync_pol (HSYNC_POL),
        .count    (bus.hCount),
        .wrap     (hWrap),
        .vis      (bus.hVis),
        .sync     (bus.hSync),
        .active   (hAct_unused)
    );

    // Vertical axis advances only on the horizontal wrap edge, so vSync,
    // vVis and vActive move together with vCount.
    vga_axis_counter #(
        .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .LEAD(ACT_LEAD), .W(VW)
    ) u_v (
        .clk      (clk),
        .nrst     (nrst),
        .step     (bus.ce & hWrap),
        .sync_pol (VSYNC_POL),
        .count    (bus.vCount),
        .wrap     (vWrap),
        .vis      (bus.vVis),
        .sync     (bus.vSync),
        .active   (bus.vActive)
    );

    // Markers are decoded one step ahead so they line up with the counters:
    // lineEnd for the next position is "current is H_TOTAL-2", frameStart
    // for the next position is "both axes wrap now".
    always_comb begin
        lineEnd_d    = lineEnd_q;
        frameStart_d = frameStart_q;
        if (!nrst) begin
            lineEnd_d    = 1'b1;
            frameStart_d = 1'b0;
        end else if (bus.ce) begin
            lineEnd_d    = (bus.hCount == HW'(H_TOTAL - 2));
            frameStart_d = hWrap & vWrap;
        end
    end

    always_ff @(posedge clk) begin
        lineEnd_q    <= lineEnd_d;
        frameStart_q <= frameStart_d;
    end

    assign bus.lineEnd    = lineEnd_q;
    assign bus.frameStart = frameStart_q;
    assign bus.nVis       = ~(bus.hVis & bus.vVis);

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
    localparam int NC = 3;
    // Config 0: 640x480 defaults; 1: tiny mode, positive syncs; 2: mid mode, lead 0
    localparam int HVIS[NC] = '{640, 8, 20};
    localparam int HFP [NC] = '{16, 2, 3};
    localparam int HSY [NC] = '{96, 2, 4};
    localparam int HBP [NC] = '{48, 2, 5};
    localparam int VVIS[NC] = '{480, 4, 12};
    localparam int VFP [NC] = '{10, 1, 2};
    localparam int VSY [NC] = '{2, 1, 3};
    localparam int VBP [NC] = '{33, 1, 4};
    localparam int LEAD[NC] = '{1, 1, 0};
    localparam bit HPOL[NC] = '{1'b0, 1'b1, 1'b0};
    localparam bit VPOL[NC] = '{1'b0, 1'b1, 1'b1};

    typedef struct packed {
        logic [9:0] hc;
        logic [9:0] vc;
        logic hs, vs, hv, vv, nv, va, le, fs;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0] nrst_v;

    vga_timing_gen_if #(.HW(10), .VW(10)) bus0 ();
    vga_timing_gen_if #(.HW(10), .VW(10)) bus1 ();
    vga_timing_gen_if #(.HW(10), .VW(10)) bus2 ();

    vga_timing_gen u_a (.clk(clk), .nrst(nrst_v[0]), .bus(bus0));

    vga_timing_gen #(
        .H_VIS(HVIS[1]), .H_FP(HFP[1]), .H_SYNC(HSY[1]), .H_BP(HBP[1]),
        .V_VIS(VVIS[1]), .V_FP(VFP[1]), .V_SYNC(VSY[1]), .V_BP(VBP[1]),
        .HSYNC_POL(HPOL[1]), .VSYNC_POL(VPOL[1]), .ACT_LEAD(LEAD[1]), .HW(10), .VW(10)
    ) u_b (.clk(clk), .nrst(nrst_v[1]), .bus(bus1));

    vga_timing_gen #(
        .H_VIS(HVIS[2]), .H_FP(HFP[2]), .H_SYNC(HSY[2]), .H_BP(HBP[2]),
        .V_VIS(VVIS[2]), .V_FP(VFP[2]), .V_SYNC(VSY[2]), .V_BP(VBP[2]),
        .HSYNC_POL(HPOL[2]), .VSYNC_POL(VPOL[2]), .ACT_LEAD(LEAD[2]), .HW(10), .VW(10)
    ) u_c (.clk(clk), .nrst(nrst_v[2]), .bus(bus2));

    // Reference model: position is a linear pixel index within the frame.
    function automatic int htot(input int k);
        return HVIS[k] + HFP[k] + HSY[k] + HBP[k];
    endfunction
    function automatic int vtot(input int k);
        return VVIS[k] + VFP[k] + VSY[k] + VBP[k];
    endfunction

    function automatic obs_t model(input int k, input int t);
        obs_t o;
        int h, v;
        bit hs_on, vs_on;
        h = t % htot(k);
        v = t / htot(k);
        hs_on = (h >= HVIS[k] + HFP[k]) && (h < HVIS[k] + HFP[k] + HSY[k]);
        vs_on = (v >= VVIS[k] + VFP[k]) && (v < VVIS[k] + VFP[k] + VSY[k]);
        o.hc = 10'(h);
        o.vc = 10'(v);
        o.hs = hs_on ? HPOL[k] : !HPOL[k];
        o.vs = vs_on ? VPOL[k] : !VPOL[k];
        o.hv = (h < HVIS[k]);
        o.vv = (v < VVIS[k]);
        o.nv = !(o.hv && o.vv);
        // vActive is the visibility of the line LEAD lines ahead
        o.va = ((v + LEAD[k]) % vtot(k)) < VVIS[k];
        o.le = (h == htot(k) - 1);
        o.fs = (t == 0);
        return o;
    endfunction

    obs_t q[NC][$];
    int   tpos[NC];
    int   n_push = 0;
    int   n_pop = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 1'b0;

    task automatic step_cycle(input logic [NC-1:0] ce_v, input logic [NC-1:0] rst_v);
        bus0.ce = ce_v[0];
        bus1.ce = ce_v[1];
        bus2.ce = ce_v[2];
        nrst_v  = ~rst_v;
        @(posedge clk);
        #1;
        for (int k = 0; k < NC; k++) begin
            if (rst_v[k])     tpos[k] = htot(k) * vtot(k) - 1;
            else if (ce_v[k]) tpos[k] = (tpos[k] + 1) % (htot(k) * vtot(k));
            q[k].push_back(model(k, tpos[k]));
            n_push++;
        end
    endtask

    function automatic logic [NC-1:0] rand_ce();
        logic [NC-1:0] c;
        for (int k = 0; k < NC; k++) c[k] = ($urandom_range(0, 3) != 0);
        return c;
    endfunction

    // Stimulus
    initial begin
        int tgt[NC];
        int hold[NC];
        bit fired[NC];
        logic [NC-1:0] r;
        bus0.ce = 1'b0; bus1.ce = 1'b0; bus2.ce = 1'b0;
        nrst_v = '0;
        // reset with ce random: reset must win over ce
        repeat (4) step_cycle(rand_ce(), '1);
        // free run: hsync/lineEnd on full-size line, many small frames
        repeat (1800) step_cycle('1, '0);
        // ce alternating: everything holds on ce=0 cycles
        for (int i = 0; i < 1700; i++) step_cycle((i % 2 == 0) ? '1 : '0, '0);
        // mid-frame reset, inside a sync pulse of each config
        tgt[0] = 4 * 800 + 700;
        tgt[1] = 5 * 14 + 10;
        tgt[2] = 15 * 32 + 24;
        for (int k = 0; k < NC; k++) begin hold[k] = 0; fired[k] = 1'b0; end
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NC; k++) begin
                if (!fired[k] && tpos[k] == tgt[k]) begin fired[k] = 1'b1; hold[k] = 2; end
                r[k] = (hold[k] > 0);
                if (hold[k] > 0) hold[k]--;
            end
            step_cycle('1, r);
        end
        // random ce and occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NC; k++) r[k] = ($urandom_range(0, 299) == 0);
            step_cycle(rand_ce(), r);
        end
        done = 1'b1;
        #1000;
        $display("FAIL watchdog: monitor did not finish, got done=%0d want summary", done);
        $fatal(1);
    end

    task automatic check_obs(input int k, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL dut%0d @%0t: got h=%0d v=%0d hs%b vs%b hv%b vv%b nv%b va%b le%b fs%b, want h=%0d v=%0d hs%b vs%b hv%b vv%b nv%b va%b le%b fs%b",
                     k, $time, got.hc, got.vc, got.hs, got.vs, got.hv, got.vv, got.nv, got.va, got.le, got.fs,
                     want.hc, want.vc, want.hs, want.vs, want.hv, want.vv, want.nv, want.va, want.le, want.fs);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    obs_t act[NC];
    always @(negedge clk) begin
        act[0] = {bus0.hCount, bus0.vCount, bus0.hSync, bus0.vSync, bus0.hVis, bus0.vVis,
                  bus0.nVis, bus0.vActive, bus0.lineEnd, bus0.frameStart};
        act[1] = {bus1.hCount, bus1.vCount, bus1.hSync, bus1.vSync, bus1.hVis, bus1.vVis,
                  bus1.nVis, bus1.vActive, bus1.lineEnd, bus1.frameStart};
        act[2] = {bus2.hCount, bus2.vCount, bus2.hSync, bus2.vSync, bus2.hVis, bus2.vVis,
                  bus2.nVis, bus2.vActive, bus2.lineEnd, bus2.frameStart};
        for (int k = 0; k < NC; k++) begin
            if (q[k].size() > 0) begin
                check_obs(k, act[k], q[k].pop_front());
                n_pop++;
            end
        end
        if (done) begin
            n_cmp++;
            if (n_pop != n_push) begin
                n_bad++;
                $display("FAIL drain: got %0d checked, want %0d issued", n_pop, n_push);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

endmodule
